// File: rtl/fetch_controller_if.sv
// Fetch-side bus of the core: control requests from the hazard/branch logic,
// the instruction memory port, and the IF/ID register outputs.
interface fetch_controller_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_instruction;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [31:0]           if_instruction;
  logic                  fault;
  logic [31:0]           fetch_count;

  // Environment side: drives control requests and memory read data.
  modport master (
    output stall, redirect_valid, redirect_pc, halt, imem_instruction,
    input  imem_address, if_valid, if_pc, if_instruction, fault, fetch_count
  );

  // Fetch controller side.
  modport slave (
    input  stall, redirect_valid, redirect_pc, halt, imem_instruction,
    output imem_address, if_valid, if_pc, if_instruction, fault, fetch_count
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, addresses the instruction
// memory and latches returned instructions into the IF/ID register, with
// stall, redirect, halt and out-of-range fault handling.
module fetch_controller #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          MEM_WORDS  = 256,
  parameter logic [31:0]          NOP_INSTR  = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  fetch_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

  // One extra bit so MEM_WORDS*4 == 2^ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS) << 2;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH)'(3);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [31:0]           if_instruction;
  logic                  fault;
  logic [31:0]           fetch_count;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] redirect_target;

  assign out_of_range    = {1'b0, pc} >= MEM_LIMIT;
  assign redirect_target = bus.redirect_pc & ALIGN_MASK;

  assign bus.imem_address   = pc;
  assign bus.if_valid       = if_valid;
  assign bus.if_pc          = if_pc;
  assign bus.if_instruction = if_instruction;
  assign bus.fault          = fault;
  assign bus.fetch_count    = fetch_count;

  // Fetch state machine: PC sequencing and IF/ID register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_instruction <= NOP_INSTR;
      fault          <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
        end
        RUN: begin
          if (bus.halt) begin
            state          <= HALTED;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
          end else if (bus.redirect_valid) begin
            pc             <= redirect_target;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
          end else if (out_of_range) begin
            state    <= FAULT;
            fault    <= 1'b1;
            if_valid <= 1'b0;
          end else if (!bus.stall) begin
            if_instruction <= bus.imem_instruction;
            if_pc          <= pc;
            if_valid       <= 1'b1;
            pc             <= pc + ADDR_WIDTH'(4);
            if (fetch_count != '1) begin
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        HALTED: begin
          if_valid <= 1'b0;
        end
        FAULT: begin
          fault    <= 1'b1;
          if_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
